cnt_rr_sched: RTL and testbench
===============================

Name: cnt_rr_sched

Overview:
Round-robin scheduler that shares one up/down loadable counter between NREQ requesters. Each requester submits one operation: optional load, direction, and step count. The block grants one requester at a time, sequences the counter through the operation, and returns the final count with the requester ID. It sits between the requester agents and the counter datapath; it contains that datapath as a sub-module.

Parameters:
NREQ, 4, number of requesters (≥2)
WIDTH, 4, counter width
STEPW, 4, width of per-request step count

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
req_valid  input  NREQ  request pending, one bit per requester
req_ready  output  NREQ  one-hot accept strobe
req_load_en  input  NREQ  request loads before stepping
req_load  input  NREQ*WIDTH  load value; slice i belongs to requester i
req_down  input  NREQ  1 = count down, 0 = count up
req_steps  input  NREQ*STEPW  number of ±1 steps
busy  output  1  operation in progress (state != IDLE)
owner  output  $clog2(NREQ)  ID of current/last granted requester
count  output  WIDTH  live counter value
rollover  output  1  &count (combinational)
done_valid  output  1  one-cycle completion pulse
done_id  output  $clog2(NREQ)  requester that completed
done_count  output  WIDTH  count after the final step

Behaviour:
- Reset (async, rstn=0): state=IDLE, count=0, rr_ptr=0, owner=0, busy=0, done_valid=0, done_id=0, done_count=0. req_ready=0 while rstn=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: winner = first i with req_valid[i], searching from rr_ptr upward, wrapping modulo NREQ. req_ready[winner]=1 combinationally in the same cycle; no other ready bit is high.
- On that edge: capture load_en, load, down, steps of the winner; owner<=winner; rr_ptr<=(winner+1) mod NREQ.
  - Next state LOAD if load_en=1.
  - Otherwise RUN if steps≠0.
  - Otherwise DONE.
- No valid in IDLE: stay in IDLE, all ready=0, count holds.
- LOAD (1 cycle): count<=load. Does not consume a step. Next state RUN if steps≠0, else DONE.
- RUN: each cycle count<=count±1 and remaining steps decremented. Leaves for DONE on the edge that performs the last step.
- Arithmetic: modulo 2^WIDTH. 0xF+1=0x0 and 0x0−1=0xF (WIDTH=4).
- DONE (1 cycle): done_valid=1, done_id=owner, done_count=count. Next state IDLE.
- done_id and done_count hold until the next DONE.
- Latency for accept in cycle k, with L=load_en and S=steps: DONE occurs in cycle k+L+S+1. Minimum is 2 cycles from accept to the next IDLE arbitration.
- New requests are accepted only in IDLE.
- Outside LOAD/RUN the counter holds its value.
- Requesters hold valid and payload until ready. Payload changes after accept have no effect.
- Reset asserted mid-operation aborts immediately: count=0, no done_valid pulse. After reset, arbitration restarts at rr_ptr=0.

Decomposition:
- Package cnt_sched_pkg:
  - state enum {IDLE, LOAD, RUN, DONE}
  - request struct {load_en, load[WIDTH], down, steps[STEPW]}
  - function rr_pick(valid, ptr) returning the winner index
- Sub-module cnt_core: counter datapath with ports clk, rstn, en, load_en, load, down, count, rollover.
  - Counts only when en=1.
  - load_en has priority over counting.
  - Asynchronous clear to 0.
- The scheduler instantiates one cnt_core and drives it:
  - en=1 in LOAD and RUN
  - load_en=1 in LOAD
  - down = captured down

Test Plan:
1. Reset: rstn=0 with all req_valid=1 → req_ready=0, count=0, busy=0, done_valid=0. Release rstn → req0 granted first.
2. req0 alone, load_en=1, load=0xA, down=0, steps=3 → count is 0xA, 0xB, 0xC, 0xD over 4 cycles. done_valid=1 with done_id=0, done_count=0xD exactly 5 cycles after accept.
3. Wrap, up: req2 load 0xE, up, steps=3 → count 0xE, 0xF (rollover=1), 0x0, 0x1; done_count=0x1.
   Wrap, down: follow-up with no load, down, steps=2 → 0x0, 0xF; done_count=0xF.
4. Round robin: req0, req1, req3 continuously valid, each steps=1, no load → grant order 0, 1, 3, 0, 1. req2 never gets ready. Each op takes 3 cycles (IDLE, RUN, DONE).
5. Zero-length ops:
   - steps=0, load_en=0 → DONE the cycle after accept, done_count = unchanged count.
   - steps=0, load_en=1, load=0x5 → done_count=0x5, 2 cycles after accept.
6. Reset mid-RUN: req1 up, steps=10; drop rstn after 4 steps → count=0 immediately, no done_valid. After release, req0 and req1 both valid → req0 granted.

Source files
------------

// File: rtl/cnt_sched_pkg.sv
// Shared types and the round-robin pick function for the counter scheduler.
// The request struct is sized by the package geometry; the top defaults to the same values.
package cnt_sched_pkg;

  localparam int N_REQ  = 4;
  localparam int CNT_W  = 4;
  localparam int STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              load_en;
    logic [CNT_W-1:0]  load;
    logic              down;
    logic [STEP_W-1:0] steps;
  } req_t;

  // First set bit of valid at or after ptr, wrapping modulo n; returns ptr when none is set.
  function automatic int rr_pick(input logic [31:0] valid, input int ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (valid[idx[4:0]]) begin
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/cnt_core.sv
// Loadable up/down counter datapath; load has priority over counting, wraps modulo 2^WIDTH.
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next counter value
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (load_en) begin
        count_d = load;
      end else if (down) begin
        count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign rollover = &count_q;

endmodule

// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler sharing one cnt_core among NREQ requesters.
// Each granted operation runs IDLE -> [LOAD] -> [RUN x steps] -> DONE.
module cnt_rr_sched
  import cnt_sched_pkg::*;
#(
  parameter int NREQ  = N_REQ,
  parameter int WIDTH = CNT_W,
  parameter int STEPW = STEP_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_load_en,
  input  logic [NREQ*WIDTH-1:0]    req_load,
  input  logic [NREQ-1:0]          req_down,
  input  logic [NREQ*STEPW-1:0]    req_steps,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [WIDTH-1:0]         count,
  output logic                     rollover,
  output logic                     done_valid,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [WIDTH-1:0]         done_count
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [WIDTH-1:0] done_count_q, done_count_d;
  req_t             op_q, op_d;
  logic [IDW-1:0]   winner_s;
  logic             any_valid_s;
  logic [WIDTH-1:0] load_a [NREQ];
  logic [STEPW-1:0] steps_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign load_a[g]  = req_load[g*WIDTH +: WIDTH];
    assign steps_a[g] = req_steps[g*STEPW +: STEPW];
  end

  assign any_valid_s = |req_valid;
  assign winner_s    = IDW'(rr_pick(32'(req_valid), 32'(rr_ptr_q), NREQ));

  // One-hot accept strobe; held low while reset is asserted
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (rstn && (state_q == IDLE) && any_valid_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    done_id_d    = done_id_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (any_valid_s) begin
          op_d.load_en = req_load_en[winner_s];
          op_d.load    = load_a[winner_s];
          op_d.down    = req_down[winner_s];
          op_d.steps   = steps_a[winner_s];
          owner_d      = winner_s;
          if (winner_s == IDW'(NREQ - 1)) begin
            rr_ptr_d = {IDW{1'b0}};
          end else begin
            rr_ptr_d = winner_s + {{(IDW-1){1'b0}}, 1'b1};
          end
          if (req_load_en[winner_s]) begin
            state_d = LOAD;
          end else if (steps_a[winner_s] != {STEPW{1'b0}}) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (op_q.steps != {STEPW{1'b0}}) begin
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        op_d.steps = op_q.steps - {{(STEPW-1){1'b0}}, 1'b1};
        if (op_q.steps == {{(STEPW-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // Capture so the result stays visible after leaving DONE
        done_id_d    = owner_q;
        done_count_d = count;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= {IDW{1'b0}};
      owner_q      <= {IDW{1'b0}};
      done_id_q    <= {IDW{1'b0}};
      done_count_q <= {WIDTH{1'b0}};
      op_q         <= {$bits(req_t){1'b0}};
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      done_id_q    <= done_id_d;
      done_count_q <= done_count_d;
      op_q         <= op_d;
    end
  end

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .en       ((state_q == LOAD) || (state_q == RUN)),
    .load_en  (state_q == LOAD),
    .load     (op_q.load),
    .down     (op_q.down),
    .count    (count),
    .rollover (rollover)
  );

  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;
  assign done_valid = (state_q == DONE);
  assign done_id    = (state_q == DONE) ? owner_q : done_id_q;
  assign done_count = (state_q == DONE) ? count : done_count_q;

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Directed self-checking bench for cnt_rr_sched: inputs driven and outputs sampled in the low clock phase.
module tb_cnt_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int STEPW = 4;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         req_load_en;
  logic [NREQ*WIDTH-1:0]   req_load;
  logic [NREQ-1:0]         req_down;
  logic [NREQ*STEPW-1:0]   req_steps;
  logic                    busy;
  logic [1:0]              owner;
  logic [WIDTH-1:0]        count;
  logic                    rollover;
  logic                    done_valid;
  logic [1:0]              done_id;
  logic [WIDTH-1:0]        done_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cnt_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_load_en (req_load_en),
    .req_load    (req_load),
    .req_down    (req_down),
    .req_steps   (req_steps),
    .busy        (busy),
    .owner       (owner),
    .count       (count),
    .rollover    (rollover),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_count  (done_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic le, input logic [3:0] ld,
                         input logic dn, input logic [3:0] st);
    req_load_en[id]        = le;
    req_load[id*4 +: 4]    = ld;
    req_down[id]           = dn;
    req_steps[id*4 +: 4]   = st;
  endtask

  // Issue one op from requester id (alone) and follow it cycle by cycle to DONE and back to IDLE
  task automatic do_op(input int id, input logic le, input logic [3:0] ld, input logic dn,
                       input logic [3:0] st, input logic [3:0] cur, input logic [3:0] fin);
    int         lat;
    logic [3:0] exp;
    set_req(id, le, ld, dn, st);
    req_valid = 4'b0001 << id;
    #1;
    check("grant", 32'(req_ready), 32'(4'b0001 << id));
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    lat = int'(le) + int'(st) + 1;
    exp = cur;
    for (int c = 1; c <= lat; c++) begin
      check("count", 32'(count), 32'(exp));
      check("rollover", 32'(rollover), 32'(exp == 4'hF));
      check("owner", 32'(owner), id);
      if (c == lat) begin
        check("done_valid", 32'(done_valid), 32'd1);
        check("done_id", 32'(done_id), id);
        check("done_count", 32'(done_count), 32'(fin));
      end else begin
        check("no_done", 32'(done_valid), 32'd0);
        check("busy", 32'(busy), 32'd1);
        if (le && c == 1) exp = ld;
        else if (dn) exp = exp - 4'd1;
        else exp = exp + 4'd1;
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done_valid), 32'd0);
    check("done_hold", 32'(done_count), 32'(fin));
  endtask

  initial begin
    int ord [5];
    ord = '{0, 1, 3, 0, 1};
    req_valid   = 4'b1111;
    req_load_en = 4'b0000;
    req_load    = 16'h0000;
    req_down    = 4'b0000;
    req_steps   = 16'h1111;
    rstn        = 1'b0;

    // 1. reset with everybody requesting
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_valid), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_done_cnt", 32'(done_count), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'b0001);

    // 2. load 0xA, up 3 -> 0xD
    do_op(0, 1'b1, 4'hA, 1'b0, 4'd3, 4'h0, 4'hD);

    // 3. wrap up then wrap down
    do_op(2, 1'b1, 4'hE, 1'b0, 4'd3, 4'hD, 4'h1);
    do_op(3, 1'b0, 4'h0, 1'b1, 4'd2, 4'h1, 4'hF);

    // 4. round robin among 0,1,3 with rr_ptr back at 0
    set_req(0, 1'b0, 4'h0, 1'b0, 4'd1);
    set_req(1, 1'b0, 4'h0, 1'b0, 4'd1);
    set_req(3, 1'b0, 4'h0, 1'b0, 4'd1);
    req_valid = 4'b1011;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << ord[g]));
      @(negedge clk);
      #1;
      check("rr_owner", 32'(owner), ord[g]);
      check("rr_busy", 32'(busy), 32'd1);
      check("rr_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      check("rr_done", 32'(done_valid), 32'd1);
      check("rr_done_id", 32'(done_id), ord[g]);
      check("rr_done_cnt", 32'(done_count), g);
      if (g == 4) req_valid = 4'b0000;
      @(negedge clk);
      #1;
    end

    // 5. zero-length ops
    do_op(2, 1'b0, 4'h0, 1'b0, 4'd0, 4'h4, 4'h4);
    do_op(3, 1'b1, 4'h5, 1'b0, 4'd0, 4'h4, 4'h5);

    // 6. reset in the middle of a long RUN
    set_req(1, 1'b0, 4'h0, 1'b0, 4'd10);
    req_valid = 4'b0010;
    #1;
    check("r6_grant", 32'(req_ready), 32'b0010);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check("r6_count", 32'(count), 32'(4 + c));
    end
    rstn = 1'b0;
    #1;
    check("r6_cnt_clr", 32'(count), 32'd0);
    check("r6_busy", 32'(busy), 32'd0);
    check("r6_done", 32'(done_valid), 32'd0);
    set_req(0, 1'b0, 4'h0, 1'b0, 4'd1);
    req_valid = 4'b0011;
    #1;
    check("r6_rst_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("r6_no_done", 32'(done_valid), 32'd0);
      check("r6_hold0", 32'(count), 32'd0);
    end
    rstn = 1'b1;
    #1;
    check("r6_regrant", 32'(req_ready), 32'b0001);
    do_op(0, 1'b0, 4'h0, 1'b0, 4'd1, 4'h0, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
